procyon_lsu_am: RTL and testbench
=================================

// Module: procyon_lsu_am
// PURPOSE
// LSU address/arbitration stage feeding the dcache D1 stage. Each cycle selects one op from SQ retire, LQ replay or a
// new RS op, computes the new-op address and registers the D1 input bundle. Issues LQ/SQ allocation for new ops and
// back-pressures the RS; fixed priority plus a starvation counter guarantees new-op forward progress.
// PARAMETERS
// OPTN_DATA_WIDTH     32  data width
// OPTN_ADDR_WIDTH     32  address width
// OPTN_LQ_DEPTH        8  LQ entries (one-hot select width)
// OPTN_SQ_DEPTH        8  SQ entries (one-hot select width)
// OPTN_ROB_IDX_WIDTH   5  ROB tag width
// OPTN_STARVE_LIMIT    4  consecutive denied cycles before a new op is forced to win (>=1)
// PORTS
// clk                    in   1      clock
// rst                    in   1      reset; one clock; reset is synchronous and active-high
// i_flush                in   1      pipeline flush
// i_fu_valid             in   1      new op from RS
// i_fu_lsu_func          in   FUNCW  LSU func (FUNCW = `PCYN_LSU_FUNC_WIDTH); store = SB/SH/SW, else load
// i_fu_op1               in   ADDR   base address
// i_fu_op2               in   DATA   store data
// i_fu_imm               in   DATA   offset
// i_fu_tag               in   ROBW   ROB tag
// o_fu_stall             out  1      new op not accepted this cycle
// i_lq_full/i_sq_full    in   1      LQ/SQ cannot allocate
// i_alloc_sq_select      in   SQD    one-hot SQ entry to allocate for a new store
// o_alloc_lq_en          out  1      allocate LQ entry (new load accepted)
// o_alloc_sq_en          out  1      allocate SQ entry (new store accepted)
// i_replay_en            in   1      LQ replay request
// i_replay_select        in   LQD    one-hot LQ entry
// i_replay_lsu_func/i_replay_addr/i_replay_tag  in  FUNCW/ADDR/ROBW  replayed op
// o_replay_ack           out  1      replay taken
// i_sq_retire_en         in   1      SQ retire request
// i_sq_retire_select     in   SQD    one-hot SQ entry
// i_sq_retire_lsu_func/_addr/_data/_tag  in  FUNCW/ADDR/DATA/ROBW  retiring store
// o_sq_retire_ack        out  1      retire taken
// o_valid,o_lsu_func,o_lq_select,o_sq_select,o_tag,o_addr,o_retire_data,o_retire,o_replay  out  -> D1 bundle
// BEHAVIOUR
// - Arbitration (combinational, same cycle): default SQ retire > LQ replay > new op.
// - new op eligible = i_fu_valid & ~(load & i_lq_full) & ~(store & i_sq_full) & ~i_flush.
// - starve_cnt (width $clog2(OPTN_STARVE_LIMIT+1)): +1 (saturating) each cycle new op eligible but not granted;
//   cleared on grant or when not eligible. When starve_cnt==OPTN_STARVE_LIMIT an eligible new op wins over both.
// - Exactly one grant per cycle max; *_ack/o_alloc_*_en are combinational pulses in the grant cycle only.
// - o_fu_stall = i_fu_valid & ~new-op grant (includes full and flush cases).
// - o_alloc_lq_en = grant & load; o_alloc_sq_en = grant & store.
// - Address: new op = i_fu_op1 + i_fu_imm[ADDR-1:0], wraps mod 2^OPTN_ADDR_WIDTH; replay/retire addr passed through.
// - Registered outputs, 1-cycle latency to D1 by grant source:
//   retire: o_retire=1,o_replay=0,o_sq_select=retire select,o_lq_select=0,o_retire_data=retire data.
//   replay: o_replay=1,o_retire=0,o_lq_select=replay select,o_sq_select=0,o_retire_data=0.
//   new:    o_replay=0,o_retire=0,o_lq_select=0,o_sq_select=store?i_alloc_sq_select:0,o_retire_data=i_fu_op2.
// - o_valid <= grant & (~i_flush | retire grant): committed SQ retires survive flush; replay and new ops are not
//   acked during i_flush (no grant). D1 never back-pressures.
// - Reset: o_valid, o_retire, o_replay, starve_cnt, all selects/addr/data/tag/func regs = 0; combinational outputs
//   follow inputs (no grant while rst high). Reset mid-stream drops the in-flight op; o_valid=0 the cycle after.
// TESTING
// - New load op1=0x1000,imm=0xFFFFFFFC, no contention -> o_alloc_lq_en=1 same cycle; next cycle o_valid=1,o_addr=0xFFC.
// - Retire+replay+new all valid -> o_sq_retire_ack=1 only, o_fu_stall=1, o_replay_ack=0; next cycle o_retire=1.
// - Replay held valid, new op held valid, LIMIT=4 -> new op stalled 4 cycles, granted 5th cycle, replay_ack=0 then.
// - Store with i_sq_full=1 -> o_fu_stall=1, starve_cnt stays 0, no alloc; deassert full -> accepted, o_sq_select=alloc.
// - i_flush with retire+new valid -> retire acked, next o_valid=1,o_retire=1; flush with only new op -> o_valid=0.
// - rst asserted mid-stream -> next cycle o_valid=0, o_retire=0, o_replay=0, all acks 0 while rst high.

Source files
------------

// File: rtl/procyon_lsu_am.sv
// procyon_lsu_am - LSU address/arbitration stage feeding the dcache D1 stage.
// Picks one of SQ retire / LQ replay / new RS op per cycle and registers the D1 bundle.
`ifndef PCYN_LSU_FUNC_WIDTH
`define PCYN_LSU_FUNC_WIDTH 3
`endif

module procyon_lsu_am #(
  parameter int OPTN_DATA_WIDTH    = 32,
  parameter int OPTN_ADDR_WIDTH    = 32,
  parameter int OPTN_LQ_DEPTH      = 8,
  parameter int OPTN_SQ_DEPTH      = 8,
  parameter int OPTN_ROB_IDX_WIDTH = 5,
  parameter int OPTN_STARVE_LIMIT  = 4
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            i_flush,

  input  logic                            i_fu_valid,
  input  logic [`PCYN_LSU_FUNC_WIDTH-1:0] i_fu_lsu_func,
  input  logic [OPTN_ADDR_WIDTH-1:0]      i_fu_op1,
  input  logic [OPTN_DATA_WIDTH-1:0]      i_fu_op2,
  input  logic [OPTN_DATA_WIDTH-1:0]      i_fu_imm,
  input  logic [OPTN_ROB_IDX_WIDTH-1:0]   i_fu_tag,
  output logic                            o_fu_stall,

  input  logic                            i_lq_full,
  input  logic                            i_sq_full,
  input  logic [OPTN_SQ_DEPTH-1:0]        i_alloc_sq_select,
  output logic                            o_alloc_lq_en,
  output logic                            o_alloc_sq_en,

  input  logic                            i_replay_en,
  input  logic [OPTN_LQ_DEPTH-1:0]        i_replay_select,
  input  logic [`PCYN_LSU_FUNC_WIDTH-1:0] i_replay_lsu_func,
  input  logic [OPTN_ADDR_WIDTH-1:0]      i_replay_addr,
  input  logic [OPTN_ROB_IDX_WIDTH-1:0]   i_replay_tag,
  output logic                            o_replay_ack,

  input  logic                            i_sq_retire_en,
  input  logic [OPTN_SQ_DEPTH-1:0]        i_sq_retire_select,
  input  logic [`PCYN_LSU_FUNC_WIDTH-1:0] i_sq_retire_lsu_func,
  input  logic [OPTN_ADDR_WIDTH-1:0]      i_sq_retire_addr,
  input  logic [OPTN_DATA_WIDTH-1:0]      i_sq_retire_data,
  input  logic [OPTN_ROB_IDX_WIDTH-1:0]   i_sq_retire_tag,
  output logic                            o_sq_retire_ack,

  output logic                            o_valid,
  output logic [`PCYN_LSU_FUNC_WIDTH-1:0] o_lsu_func,
  output logic [OPTN_LQ_DEPTH-1:0]        o_lq_select,
  output logic [OPTN_SQ_DEPTH-1:0]        o_sq_select,
  output logic [OPTN_ROB_IDX_WIDTH-1:0]   o_tag,
  output logic [OPTN_ADDR_WIDTH-1:0]      o_addr,
  output logic [OPTN_DATA_WIDTH-1:0]      o_retire_data,
  output logic                            o_retire,
  output logic                            o_replay
);

  localparam int FUNCW    = `PCYN_LSU_FUNC_WIDTH;
  localparam int STARVE_W = $clog2(OPTN_STARVE_LIMIT + 1);
  localparam logic [FUNCW-1:0] FUNC_SB = FUNCW'(5);
  localparam logic [FUNCW-1:0] FUNC_SH = FUNCW'(6);
  localparam logic [FUNCW-1:0] FUNC_SW = FUNCW'(7);
  localparam logic [STARVE_W-1:0] STARVE_MAX = STARVE_W'(OPTN_STARVE_LIMIT);

  logic [STARVE_W-1:0]        starve_cnt;
  logic                       fu_is_store;
  logic                       fu_eligible;
  logic                       starved;
  logic                       retire_req;
  logic                       replay_req;
  logic                       grant_retire;
  logic                       grant_replay;
  logic                       grant_new;
  logic [OPTN_ADDR_WIDTH-1:0] fu_addr;

  always_comb begin
    fu_is_store  = (i_fu_lsu_func == FUNC_SB) || (i_fu_lsu_func == FUNC_SH) ||
                   (i_fu_lsu_func == FUNC_SW);
    fu_eligible  = i_fu_valid & ~(~fu_is_store & i_lq_full) & ~(fu_is_store & i_sq_full) & ~i_flush;
    starved      = fu_eligible & (starve_cnt == STARVE_MAX);
    // Committed retires must drain even across a flush; replays are squashed by it
    retire_req   = i_sq_retire_en;
    replay_req   = i_replay_en & ~i_flush;
    grant_retire = ~rst & ~starved & retire_req;
    grant_replay = ~rst & ~starved & ~retire_req & replay_req;
    grant_new    = ~rst & fu_eligible & (starved | (~retire_req & ~replay_req));
    fu_addr      = i_fu_op1 + i_fu_imm[OPTN_ADDR_WIDTH-1:0];
  end

  assign o_sq_retire_ack = grant_retire;
  assign o_replay_ack    = grant_replay;
  assign o_fu_stall      = i_fu_valid & ~grant_new;
  assign o_alloc_lq_en   = grant_new & ~fu_is_store;
  assign o_alloc_sq_en   = grant_new & fu_is_store;

  always_ff @(posedge clk) begin
    if (rst || ~fu_eligible || grant_new) begin
      starve_cnt <= '0;
    end else if (starve_cnt != STARVE_MAX) begin
      starve_cnt <= starve_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      o_valid       <= 1'b0;
      o_retire      <= 1'b0;
      o_replay      <= 1'b0;
      o_lsu_func    <= '0;
      o_lq_select   <= '0;
      o_sq_select   <= '0;
      o_tag         <= '0;
      o_addr        <= '0;
      o_retire_data <= '0;
    end else begin
      o_valid       <= grant_retire | grant_replay | grant_new;
      o_retire      <= grant_retire;
      o_replay      <= grant_replay;
      o_lsu_func    <= '0;
      o_lq_select   <= '0;
      o_sq_select   <= '0;
      o_tag         <= '0;
      o_addr        <= '0;
      o_retire_data <= '0;
      if (grant_retire) begin
        o_lsu_func    <= i_sq_retire_lsu_func;
        o_sq_select   <= i_sq_retire_select;
        o_tag         <= i_sq_retire_tag;
        o_addr        <= i_sq_retire_addr;
        o_retire_data <= i_sq_retire_data;
      end else if (grant_replay) begin
        o_lsu_func  <= i_replay_lsu_func;
        o_lq_select <= i_replay_select;
        o_tag       <= i_replay_tag;
        o_addr      <= i_replay_addr;
      end else if (grant_new) begin
        o_lsu_func    <= i_fu_lsu_func;
        o_sq_select   <= fu_is_store ? i_alloc_sq_select : '0;
        o_tag         <= i_fu_tag;
        o_addr        <= fu_addr;
        o_retire_data <= i_fu_op2;
      end
    end
  end

endmodule

// File: tb/tb_procyon_lsu_am.sv
// tb/tb_procyon_lsu_am.sv - directed self-checking bench for procyon_lsu_am.
module tb_procyon_lsu_am;

  localparam logic [2:0] LW = 3'd2;
  localparam logic [2:0] SW = 3'd7;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_flush;
  logic        i_fu_valid;
  logic [2:0]  i_fu_lsu_func;
  logic [31:0] i_fu_op1, i_fu_op2, i_fu_imm;
  logic [4:0]  i_fu_tag;
  logic        o_fu_stall;
  logic        i_lq_full, i_sq_full;
  logic [7:0]  i_alloc_sq_select;
  logic        o_alloc_lq_en, o_alloc_sq_en;
  logic        i_replay_en;
  logic [7:0]  i_replay_select;
  logic [2:0]  i_replay_lsu_func;
  logic [31:0] i_replay_addr;
  logic [4:0]  i_replay_tag;
  logic        o_replay_ack;
  logic        i_sq_retire_en;
  logic [7:0]  i_sq_retire_select;
  logic [2:0]  i_sq_retire_lsu_func;
  logic [31:0] i_sq_retire_addr, i_sq_retire_data;
  logic [4:0]  i_sq_retire_tag;
  logic        o_sq_retire_ack;
  logic        o_valid;
  logic [2:0]  o_lsu_func;
  logic [7:0]  o_lq_select, o_sq_select;
  logic [4:0]  o_tag;
  logic [31:0] o_addr, o_retire_data;
  logic        o_retire, o_replay;

  int n_checks = 0;
  int n_fails  = 0;

  always #5 clk = ~clk;

  procyon_lsu_am dut (
    .clk(clk), .rst(rst), .i_flush(i_flush),
    .i_fu_valid(i_fu_valid), .i_fu_lsu_func(i_fu_lsu_func), .i_fu_op1(i_fu_op1),
    .i_fu_op2(i_fu_op2), .i_fu_imm(i_fu_imm), .i_fu_tag(i_fu_tag), .o_fu_stall(o_fu_stall),
    .i_lq_full(i_lq_full), .i_sq_full(i_sq_full), .i_alloc_sq_select(i_alloc_sq_select),
    .o_alloc_lq_en(o_alloc_lq_en), .o_alloc_sq_en(o_alloc_sq_en),
    .i_replay_en(i_replay_en), .i_replay_select(i_replay_select),
    .i_replay_lsu_func(i_replay_lsu_func), .i_replay_addr(i_replay_addr),
    .i_replay_tag(i_replay_tag), .o_replay_ack(o_replay_ack),
    .i_sq_retire_en(i_sq_retire_en), .i_sq_retire_select(i_sq_retire_select),
    .i_sq_retire_lsu_func(i_sq_retire_lsu_func), .i_sq_retire_addr(i_sq_retire_addr),
    .i_sq_retire_data(i_sq_retire_data), .i_sq_retire_tag(i_sq_retire_tag),
    .o_sq_retire_ack(o_sq_retire_ack),
    .o_valid(o_valid), .o_lsu_func(o_lsu_func), .o_lq_select(o_lq_select),
    .o_sq_select(o_sq_select), .o_tag(o_tag), .o_addr(o_addr),
    .o_retire_data(o_retire_data), .o_retire(o_retire), .o_replay(o_replay)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Inputs change on the falling edge; outputs are sampled #1 later.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  task automatic idle();
    i_flush = 0; i_fu_valid = 0; i_fu_lsu_func = LW; i_fu_op1 = 0; i_fu_op2 = 0;
    i_fu_imm = 0; i_fu_tag = 0; i_lq_full = 0; i_sq_full = 0; i_alloc_sq_select = 0;
    i_replay_en = 0; i_replay_select = 0; i_replay_lsu_func = 0; i_replay_addr = 0;
    i_replay_tag = 0; i_sq_retire_en = 0; i_sq_retire_select = 0;
    i_sq_retire_lsu_func = 0; i_sq_retire_addr = 0; i_sq_retire_data = 0; i_sq_retire_tag = 0;
  endtask

  task automatic set_new(input logic [2:0] func, input logic [31:0] op1, input logic [31:0] imm,
                         input logic [31:0] op2, input logic [4:0] tag);
    i_fu_valid = 1; i_fu_lsu_func = func; i_fu_op1 = op1; i_fu_imm = imm;
    i_fu_op2 = op2; i_fu_tag = tag;
  endtask

  task automatic set_retire();
    i_sq_retire_en = 1; i_sq_retire_select = 8'h04; i_sq_retire_lsu_func = SW;
    i_sq_retire_addr = 32'h200; i_sq_retire_data = 32'h55; i_sq_retire_tag = 5'd7;
  endtask

  task automatic set_replay();
    i_replay_en = 1; i_replay_select = 8'h02; i_replay_lsu_func = LW;
    i_replay_addr = 32'h300; i_replay_tag = 5'd9;
  endtask

  initial begin
    idle();
    rst = 1;
    @(negedge clk);
    step();
    step();
    check("reset_valid", o_valid, 0);
    check("reset_retire", o_retire, 0);
    check("reset_replay", o_replay, 0);
    check("reset_addr", o_addr, 0);
    check("reset_stall", o_fu_stall, 0);

    // Plain load with address wrap
    rst = 0;
    set_new(LW, 32'h1000, 32'hFFFF_FFFC, 32'hDEAD, 5'd3);
    #1;
    check("ld_alloc_lq", o_alloc_lq_en, 1);
    check("ld_alloc_sq", o_alloc_sq_en, 0);
    check("ld_stall", o_fu_stall, 0);
    step();
    check("ld_valid", o_valid, 1);
    check("ld_addr", o_addr, 32'hFFC);
    check("ld_tag", o_tag, 3);
    check("ld_data", o_retire_data, 32'hDEAD);
    check("ld_retire", o_retire, 0);
    set_new(LW, 32'hFFFF_FFF0, 32'h20, 0, 5'd4);
    step();
    check("wrap_addr", o_addr, 32'h10);

    // All three sources: retire wins
    set_retire();
    set_replay();
    #1;
    check("all_retire_ack", o_sq_retire_ack, 1);
    check("all_replay_ack", o_replay_ack, 0);
    check("all_stall", o_fu_stall, 1);
    check("all_alloc_lq", o_alloc_lq_en, 0);
    step();
    check("ret_valid", o_valid, 1);
    check("ret_retire", o_retire, 1);
    check("ret_replay", o_replay, 0);
    check("ret_sq_sel", o_sq_select, 8'h04);
    check("ret_lq_sel", o_lq_select, 0);
    check("ret_addr", o_addr, 32'h200);
    check("ret_data", o_retire_data, 32'h55);
    check("ret_tag", o_tag, 7);
    idle();
    step();
    check("idle_valid", o_valid, 0);

    // Starvation: replay held against a new load
    set_replay();
    set_new(LW, 32'h4000, 32'h8, 0, 5'd11);
    for (int c = 0; c < 4; c++) begin
      #1;
      check("starve_stall", o_fu_stall, 1);
      check("starve_replay_ack", o_replay_ack, 1);
      step();
      check("starve_o_replay", o_replay, 1);
      check("starve_lq_sel", o_lq_select, 8'h02);
    end
    #1;
    check("forced_stall", o_fu_stall, 0);
    check("forced_replay_ack", o_replay_ack, 0);
    check("forced_alloc_lq", o_alloc_lq_en, 1);
    step();
    check("forced_valid", o_valid, 1);
    check("forced_o_replay", o_replay, 0);
    check("forced_addr", o_addr, 32'h4008);
    idle();
    step();

    // Store blocked by SQ full must not build up starvation
    set_new(SW, 32'h800, 32'h4, 32'hCAFE, 5'd12);
    i_sq_full = 1;
    i_alloc_sq_select = 8'h10;
    #1;
    check("full_stall", o_fu_stall, 1);
    check("full_alloc_sq", o_alloc_sq_en, 0);
    for (int c = 0; c < 5; c++) step();
    check("full_valid", o_valid, 0);
    i_sq_full = 0;
    set_replay();
    #1;
    check("full_nostarve_replay", o_replay_ack, 1);
    check("full_nostarve_stall", o_fu_stall, 1);
    step();
    i_replay_en = 0;
    #1;
    check("st_alloc_sq", o_alloc_sq_en, 1);
    check("st_alloc_lq", o_alloc_lq_en, 0);
    step();
    check("st_valid", o_valid, 1);
    check("st_sq_sel", o_sq_select, 8'h10);
    check("st_data", o_retire_data, 32'hCAFE);
    check("st_addr", o_addr, 32'h804);
    check("st_retire", o_retire, 0);
    idle();
    step();

    // Flush: retire survives, new op dropped
    i_flush = 1;
    set_retire();
    set_new(LW, 32'h100, 0, 0, 5'd1);
    #1;
    check("flush_retire_ack", o_sq_retire_ack, 1);
    check("flush_stall", o_fu_stall, 1);
    step();
    check("flush_ret_valid", o_valid, 1);
    check("flush_ret_retire", o_retire, 1);
    i_sq_retire_en = 0;
    #1;
    check("flush_new_stall", o_fu_stall, 1);
    check("flush_new_alloc", o_alloc_lq_en, 0);
    step();
    check("flush_new_valid", o_valid, 0);
    idle();

    // Reset mid-stream
    set_new(LW, 32'h100, 0, 0, 5'd1);
    step();
    check("pre_rst_valid", o_valid, 1);
    rst = 1;
    set_retire();
    set_replay();
    #1;
    check("rst_retire_ack", o_sq_retire_ack, 0);
    check("rst_replay_ack", o_replay_ack, 0);
    check("rst_alloc_lq", o_alloc_lq_en, 0);
    check("rst_stall", o_fu_stall, 1);
    step();
    check("rst_valid", o_valid, 0);
    check("rst_o_retire", o_retire, 0);
    check("rst_o_replay", o_replay, 0);
    check("rst_addr", o_addr, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
